// File: rtl/mem_copy_pkg.sv
// mem_copy_pkg: shared state encoding, mode constants and default widths for the copy engine
package mem_copy_pkg;
  localparam int AW_DEF = 9;
  localparam int DW_DEF = 32;
  localparam int LW_DEF = 7;
  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;
  typedef enum logic [2:0] {IDLE, CHECK, RD, WR, FIN} state_t;
endpackage

// File: rtl/mem_copy_if.sv
// mem_copy_if: request/status handshake plus data-memory port of the copy engine
interface mem_copy_if
  import mem_copy_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) ();
  logic          start;
  logic          mode;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [LW-1:0] len;
  logic [DW-1:0] fill_data;
  logic          abort;
  logic          busy;
  logic          done;
  logic          err;
  logic [LW-1:0] xfer_cnt;
  logic          mem_re;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  modport master (
    input  start, mode, src_addr, dst_addr, len, fill_data, abort, mem_rdata,
    output busy, done, err, xfer_cnt, mem_re, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    output start, mode, src_addr, dst_addr, len, fill_data, abort, mem_rdata,
    input  busy, done, err, xfer_cnt, mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/copy_range_check.sv
// copy_range_check: overflow check, memmove direction choice and starting pointers for one request
module copy_range_check
  import mem_copy_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
  output logic          zero,
  output logic          range_err,
  output logic          desc,
  output logic [AW-1:0] src_start,
  output logic [AW-1:0] dst_start
);
  logic [AW:0] src_end;
  logic [AW:0] dst_end;
  logic        src_over;
  logic        dst_over;
  assign src_end   = {1'b0, src} + (AW+1)'(len);
  assign dst_end   = {1'b0, dst} + (AW+1)'(len);
  // one-past-end may equal 2^AW exactly; anything beyond leaves the memory
  assign src_over  = src_end[AW] && |src_end[AW-1:0];
  assign dst_over  = dst_end[AW] && |dst_end[AW-1:0];
  assign zero      = len == '0;
  assign range_err = dst_over || (mode == MODE_COPY && src_over);
  assign desc      = mode == MODE_COPY && dst > src && {1'b0, dst} < src_end;
  assign src_start = desc ? AW'(src_end - 1'b1) : src;
  assign dst_start = desc ? AW'(dst_end - 1'b1) : dst;
endmodule

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: multi-cycle memmove/fill engine owning the data-memory port while busy
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input logic clk,
  input logic reset,
  mem_copy_if.master bus
);
  state_t        state;
  logic [AW-1:0] src_p, dst_p, src_nx, dst_nx, src_start, dst_start, addr;
  logic [LW-1:0] rem, cnt;
  logic [DW-1:0] fill_r;
  logic          mode_r, desc_r, abort_r, busy, done, err, re, we;
  logic          zero, range_err, desc, last;
  copy_range_check #(.AW(AW), .LW(LW)) u_chk (
    .mode(mode_r), .src(src_p), .dst(dst_p), .len(rem),
    .zero(zero), .range_err(range_err), .desc(desc),
    .src_start(src_start), .dst_start(dst_start)
  );
  assign src_nx = desc_r ? src_p - 1'b1 : src_p + 1'b1;
  assign dst_nx = desc_r ? dst_p - 1'b1 : dst_p + 1'b1;
  // an abort seen during RD is held so the word it was reading still lands
  assign last   = rem == LW'(1) || bus.abort || abort_r;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      re      <= 1'b0;
      we      <= 1'b0;
      addr    <= '0;
      cnt     <= '0;
      src_p   <= '0;
      dst_p   <= '0;
      rem     <= '0;
      fill_r  <= '0;
      mode_r  <= MODE_COPY;
      desc_r  <= 1'b0;
      abort_r <= 1'b0;
    end else
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (bus.start) begin
            state   <= CHECK;
            busy    <= 1'b1;
            cnt     <= '0;
            src_p   <= bus.src_addr;
            dst_p   <= bus.dst_addr;
            rem     <= bus.len;
            mode_r  <= bus.mode;
            fill_r  <= bus.fill_data;
            abort_r <= 1'b0;
          end
        end
        CHECK:
          if (zero || range_err) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= range_err;
          end else begin
            src_p  <= src_start;
            dst_p  <= dst_start;
            desc_r <= desc;
            state  <= mode_r == MODE_COPY ? RD : WR;
            re     <= mode_r == MODE_COPY;
            we     <= mode_r == MODE_FILL;
            addr   <= mode_r == MODE_COPY ? src_start : dst_start;
          end
        RD: begin
          state   <= WR;
          re      <= 1'b0;
          we      <= 1'b1;
          addr    <= dst_p;
          abort_r <= bus.abort;
        end
        WR: begin
          src_p <= src_nx;
          dst_p <= dst_nx;
          rem   <= rem - 1'b1;
          cnt   <= cnt + 1'b1;
          if (last) begin
            state <= FIN;
            we    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (mode_r == MODE_COPY) begin
            state <= RD;
            we    <= 1'b0;
            re    <= 1'b1;
            addr  <= src_nx;
          end else
            addr <= dst_nx;
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.err       = err;
  assign bus.xfer_cnt  = cnt;
  assign bus.mem_re    = re;
  assign bus.mem_we    = we;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = we ? (mode_r == MODE_FILL ? fill_r : bus.mem_rdata) : '0;
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: table-driven copy/fill vectors plus abort and reset sequences against a memmove reference
module tb_mem_copy_engine;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  mem_copy_if bus ();
  mem_copy_engine dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  logic [31:0] mem [512];
  logic [31:0] exp_mem [512];
  logic [31:0] rdata_q = '0;
  logic [8:0]  wlog [$];
  int          rd_n = 0;
  logic        both_hi = 1'b0;
  assign bus.mem_rdata = rdata_q;
  always @(posedge clk) begin
    if (bus.mem_re) begin
      rdata_q <= mem[bus.mem_addr];
      rd_n    <= rd_n + 1;
    end
    if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wlog.push_back(bus.mem_addr);
    end
    if (bus.mem_re && bus.mem_we) both_hi <= 1'b1;
  end

  typedef struct {
    logic        mode;
    logic [8:0]  src;
    logic [8:0]  dst;
    logic [6:0]  len;
    logic [31:0] fill;
    logic        exp_err;
    logic [6:0]  exp_cnt;
    int          exp_cyc;
    logic [8:0]  exp_first;
    logic [8:0]  exp_last;
  } vec_t;
  vec_t vt [12];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic start_op(input logic m, input logic [8:0] s, input logic [8:0] d,
                          input logic [6:0] l, input logic [31:0] f);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.src_addr = s; bus.dst_addr = d;
    bus.len = l; bus.fill_data = f;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic run(input int id, input vec_t v);
    logic [31:0] tmp [128];
    int cyc, d;
    foreach (mem[i]) exp_mem[i] = mem[i];
    if (!v.exp_err) begin
      for (int i = 0; i < v.len; i++) tmp[i] = exp_mem[v.src + i];
      for (int i = 0; i < v.len; i++) exp_mem[v.dst + i] = v.mode ? v.fill : tmp[i];
    end
    wlog.delete();
    rd_n = 0;
    start_op(v.mode, v.src, v.dst, v.len, v.fill);
    chk($sformatf("v%0d busy_in_check", id), bus.busy, 1);
    cyc = 0;
    while (!bus.done && cyc < 400) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk($sformatf("v%0d cycles", id), cyc, v.exp_cyc);
    chk($sformatf("v%0d err", id), bus.err, v.exp_err);
    chk($sformatf("v%0d busy_at_done", id), bus.busy, 0);
    chk($sformatf("v%0d xfer_cnt", id), bus.xfer_cnt, v.exp_cnt);
    chk($sformatf("v%0d writes", id), wlog.size(), v.exp_cnt);
    chk($sformatf("v%0d reads", id), rd_n, v.mode ? 0 : v.exp_cnt);
    if (v.exp_cnt != 0 && wlog.size() > 0) begin
      chk($sformatf("v%0d first_addr", id), wlog[0], v.exp_first);
      chk($sformatf("v%0d last_addr", id), wlog[wlog.size()-1], v.exp_last);
    end
    d = 0;
    foreach (mem[i]) if (mem[i] !== exp_mem[i]) d++;
    chk($sformatf("v%0d mem_diffs", id), d, 0);
    @(posedge clk);
    #1 chk($sformatf("v%0d done_pulse", id), {bus.done, bus.err, bus.busy}, 0);
    chk($sformatf("v%0d cnt_hold", id), bus.xfer_cnt, v.exp_cnt);
  endtask

  initial begin
    logic [31:0] pre_a1, pre_a2;
    int k;
    foreach (mem[i]) mem[i] = 32'hC0DE_0000 | i;
    bus.start = 0; bus.mode = 0; bus.src_addr = 0; bus.dst_addr = 0;
    bus.len = 0; bus.fill_data = 0; bus.abort = 0;
    vt[0]  = '{0, 9'h010, 9'h100, 7'd4,   32'h0,        0, 7'd4,   9,   9'h100, 9'h103};
    vt[1]  = '{0, 9'h020, 9'h022, 7'd4,   32'h0,        0, 7'd4,   9,   9'h025, 9'h022};
    vt[2]  = '{1, 9'h000, 9'h040, 7'd3,   32'hDEADBEEF, 0, 7'd3,   4,   9'h040, 9'h042};
    vt[3]  = '{0, 9'h005, 9'h1F0, 7'd0,   32'h0,        0, 7'd0,   1,   9'h000, 9'h000};
    vt[4]  = '{0, 9'h000, 9'h1FE, 7'd4,   32'h0,        1, 7'd0,   1,   9'h000, 9'h000};
    vt[5]  = '{0, 9'h1FC, 9'h080, 7'd4,   32'h0,        0, 7'd4,   9,   9'h080, 9'h083};
    vt[6]  = '{0, 9'h1FD, 9'h000, 7'd4,   32'h0,        1, 7'd0,   1,   9'h000, 9'h000};
    vt[7]  = '{1, 9'h1FF, 9'h1FF, 7'd1,   32'h12345678, 0, 7'd1,   2,   9'h1FF, 9'h1FF};
    vt[8]  = '{0, 9'h032, 9'h030, 7'd4,   32'h0,        0, 7'd4,   9,   9'h030, 9'h033};
    vt[9]  = '{0, 9'h050, 9'h050, 7'd3,   32'h0,        0, 7'd3,   7,   9'h050, 9'h052};
    vt[10] = '{0, 9'h070, 9'h073, 7'd3,   32'h0,        0, 7'd3,   7,   9'h073, 9'h075};
    vt[11] = '{1, 9'h1F0, 9'h181, 7'd127, 32'hA5A5F00D, 0, 7'd127, 128, 9'h181, 9'h1FF};
    repeat (3) @(posedge clk);
    #1 chk("rst_status", {bus.busy, bus.done, bus.err, bus.mem_re, bus.mem_we}, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_cnt", bus.xfer_cnt, 0);
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 12; i++) run(i, vt[i]);

    // abort during the read of word 2; a second start while busy must be dropped
    pre_a1 = mem[9'h061];
    pre_a2 = mem[9'h0A2];
    wlog.delete();
    start_op(0, 9'h060, 9'h0A0, 7'd5, 32'h0);
    repeat (3) @(posedge clk);
    #1 chk("abort_in_rd", {bus.mem_re, 23'd0, bus.mem_addr}, {1'b1, 23'd0, 9'h061});
    bus.abort = 1; bus.start = 1; bus.mode = 1; bus.dst_addr = 9'h0C0; bus.len = 7'd7;
    @(posedge clk);
    #1 bus.abort = 0; bus.start = 0;
    k = 0;
    while (!bus.done && k < 20) begin
      @(posedge clk);
      #1 k++;
    end
    chk("abort_cycles", k, 1);
    chk("abort_cnt", bus.xfer_cnt, 2);
    chk("abort_writes", wlog.size(), 2);
    chk("abort_word2", mem[9'h0A1], pre_a1);
    chk("abort_word3_untouched", mem[9'h0A2], pre_a2);
    repeat (4) @(posedge clk);
    #1 chk("busy_start_ignored", {bus.busy, 23'd0, 8'(wlog.size())}, 2);

    // asynchronous reset in the middle of a write
    start_op(0, 9'h010, 9'h140, 7'd4, 32'h0);
    k = 0;
    while (!bus.mem_we && k < 20) begin
      @(posedge clk);
      #1 k++;
    end
    chk("reached_wr", bus.mem_we, 1);
    #2 reset = 1'b0;
    #1 chk("arst_status", {bus.busy, bus.done, bus.err, bus.mem_re, bus.mem_we}, 0);
    chk("arst_addr", bus.mem_addr, 0);
    chk("arst_wdata", bus.mem_wdata, 0);
    chk("arst_cnt", bus.xfer_cnt, 0);
    @(negedge clk) reset = 1'b1;
    run(12, '{1, 9'h000, 9'h140, 7'd2, 32'h0BADCAFE, 0, 7'd2, 3, 9'h140, 9'h141});
    run(13, '{0, 9'h100, 9'h145, 7'd3, 32'h0, 0, 7'd3, 7, 9'h145, 9'h147});
    chk("re_we_exclusive", both_hi, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Multi-cycle, parametrised memory copy/fill engine; successor to the single-cycle combinational memcopy path inside the data memory.
- Sits beside the datapath and owns the data-memory port while busy; the datapath stalls PC fetch on busy.
- Adds arbitrary word length, overlap-safe (memmove) ordering, a constant-fill mode, abort, and range checking.

Parameters:
AW, 9, word address width (matches data memory depth)
DW, 32, data word width
LW, 7, length field width; max transfer 2^LW-1 words

Ports:
clk  input  1  global clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  one-cycle request pulse; sampled only in IDLE
mode  input  1  0 = copy, 1 = fill
src_addr  input  AW  first source word (ignored in fill mode)
dst_addr  input  AW  first destination word
len  input  LW  word count
fill_data  input  DW  constant written in fill mode
abort  input  1  stop at next word boundary
busy  output  1  high from the cycle after accepted start until the cycle done pulses
done  output  1  one-cycle completion pulse (normal, abort, error or zero length)
err  output  1  one-cycle pulse coincident with done on range error
xfer_cnt  output  LW  words written so far in current/last op
mem_re  output  1  data memory read strobe
mem_we  output  1  data memory write strobe
mem_addr  output  AW  data memory word address
mem_wdata  output  DW  write data
mem_rdata  input  DW  read data, valid the cycle after mem_re (1-cycle latency)

Behaviour:
- Reset (reset=0, async): state IDLE; busy, done, err, mem_re, mem_we = 0; mem_addr, mem_wdata, xfer_cnt = 0.
- States: IDLE, CHECK, RD, WR, FIN.
- IDLE: on start, latch src, dst, len, mode, fill_data -> CHECK. Starts while not in IDLE are ignored (no queueing).
- CHECK (1 cycle): len==0 -> FIN, no err. Range error if dst+len > 2^AW, or (copy) src+len > 2^AW, using AW+1-bit sums -> FIN with err. Otherwise choose direction:
  - Descending iff copy && dst > src && dst < src+len; pointers start at src+len-1 and dst+len-1.
  - Otherwise ascending, pointers start at src and dst.
  - Then copy -> RD, fill -> WR.
- RD: mem_re=1, mem_addr=src pointer -> WR.
- WR: mem_we=1, mem_addr=dst pointer, mem_wdata = mem_rdata (copy) or fill_data (fill). Step pointers +1 or -1; decrement remaining; xfer_cnt+1. If remaining becomes 0 or abort is sampled high -> FIN; else copy -> RD, fill -> WR.
- Throughput: copy is 2 cycles/word, fill is 1 cycle/word. mem_re and mem_we are never high together.
- abort: sampled in RD or WR. In RD the pending read completes and its WR still executes, then -> FIN, so no partial word is lost. Abort in CHECK or IDLE has no effect.
- FIN: done=1 (plus err if flagged), busy=0 in this cycle -> IDLE. xfer_cnt holds until the next accepted start, where it clears to 0.
- busy is 1 in CHECK, RD and WR; 0 in IDLE and FIN.
- Addresses are never wrapped: the range check guarantees pointers stay in [0, 2^AW-1].
- Reset mid-operation aborts immediately; memory contents are left partially written (no rollback).

Decomposition:
- Shared package mem_copy_pkg: state enum (IDLE, CHECK, RD, WR, FIN), mode constants MODE_COPY/MODE_FILL, default AW/DW/LW.
- One natural sub-module, copy_range_check: combinational overflow, overlap and direction decision plus start pointers, instantiated by mem_copy_engine.

Test Plan:
- Copy src=0x010, dst=0x100, len=4 (mem[0x10..0x13]=A,B,C,D) -> writes 0x100..0x103 = A..D ascending; 8 busy cycles after CHECK; done 1 cycle after last write; xfer_cnt=4.
- Overlap copy src=0x020, dst=0x022, len=4 -> descending writes to 0x025, 0x024, 0x023, 0x022 with original mem[0x023], [0x022], [0x021], [0x020]; no source corruption.
- Fill dst=0x040, len=3, fill_data=0xDEADBEEF -> 3 consecutive mem_we cycles at 0x040..0x042, mem_re never asserted.
- len=0 -> done 2 cycles after start, no mem strobes, err=0. dst=0x1FE, len=4 -> done and err together, zero writes.
- Abort raised in RD of word 2 of a len=5 copy -> word 2 still written, then done; xfer_cnt=2; start during busy ignored.
- reset driven low during WR -> all outputs 0 asynchronously; a new start after release runs normally.
